lvds_tx: RTL and testbench
==========================

// Module: lvds_tx
// PURPOSE
// Transmit-side counterpart of the LVDS DDR receive path: pulls 32-bit I/Q words from the TX FIFO
// and serialises each onto the 2-bit DDR lane to the modem, MSB pair first, 16 clocks per word.
// Wire format per word: ['10'][13b I]['0']['01'][13b Q]['0'], the same framing the RX deframer locks on.
// Sits between the TX FIFO (read side) and the LVDS output DDR cells.
// PARAMETERS
// IDLE_SYMBOL    2'b00  symbol driven when no word is in flight; must never equal 2'b10 (I sync)
// FORCE_FRAMING  1      1: overwrite word bits [31:30]=10, [16]=0, [15:14]=01, [0]=0 on load; 0: send as-is
// PORTS
// i_ddr_clk         in   1   symbol clock; one 2-bit symbol per rising edge
// i_rst_b           in   1   asynchronous reset, active low
// i_tx_enable       in   1   1: stream words; 0: finish the current word, then idle
// i_fifo_empty      in   1   TX FIFO empty flag
// i_fifo_data       in   32  FIFO read data, valid on the edge after the pull
// o_fifo_read_clk   out  1   equals i_ddr_clk
// o_fifo_pull       out  1   registered read strobe, one cycle per word
// o_ddr_data        out  2   registered symbol to the DDR output cells
// o_underrun        out  1   one-cycle pulse when a word ends while enabled and no next word is ready
// o_debug_state     out  2   00 idle, 01 transmitting
// BEHAVIOUR
// Reset values: o_ddr_data=IDLE_SYMBOL, o_fifo_pull=0, o_underrun=0, o_debug_state=00.
// Reset also clears hold_valid, the shift register and the counter.
// Reset mid-word aborts immediately; the partial word is discarded and never resent.
// Prefetch: a one-entry hold register (hold, hold_valid) decouples FIFO latency from the lane.
// - o_fifo_pull <= i_tx_enable & ~i_fifo_empty & ~hold_valid & ~o_fifo_pull.
// - On an edge where o_fifo_pull==1: hold <= i_fifo_data (framing applied if FORCE_FRAMING), hold_valid <= 1.
// - Capture never coincides with a load: a pull is only issued while the hold register is empty.
// States: IDLE, TX. 4-bit counter cnt = symbols still to send after the current one.
// IDLE edge:
// - If i_tx_enable & hold_valid: LOAD, go to TX.
// - Otherwise drive o_ddr_data=IDLE_SYMBOL.
// LOAD action:
// - o_ddr_data <= hold[31:30]; shreg <= {hold[29:0],2'b00}; cnt <= 15; hold_valid <= 0.
// TX edge with cnt!=0: o_ddr_data <= shreg[31:30]; shreg <<= 2; cnt <= cnt-1.
// TX edge with cnt==0 (last symbol of the word is on the lane):
// - i_tx_enable & hold_valid: LOAD again. Back-to-back words, no gap; next '10' directly follows the final '0'.
// - i_tx_enable & ~hold_valid: o_underrun=1 for one cycle; o_ddr_data <= IDLE_SYMBOL; go to IDLE.
// - ~i_tx_enable: o_ddr_data <= IDLE_SYMBOL; go to IDLE; no underrun.
// i_tx_enable falling mid-word has no effect until cnt==0; a word is never truncated.
// A word already in the hold register when enable drops stays there and is sent first after re-enable.
// i_fifo_empty rising after a pull was issued does not cancel that pull's capture.
// Startup latency, IDLE with enable=1 and a non-empty FIFO:
// - edge1 pull=1; edge2 hold captured; edge3 LOAD, o_ddr_data=10.
// Steady state: one pull per 16 cycles; the refill completes 2 edges after each LOAD.
// TESTING
// 1. FIFO holds 0x8000_4000 (I=0, Q=0), enable=1 -> after LOAD the lane shows 10,00x6,00,01,00x6,00.
//    o_fifo_pull fires once; the lane returns to 00 and o_underrun pulses on the edge after the 16th symbol.
// 2. Three words queued, enable=1 -> 48 consecutive symbols with no IDLE_SYMBOL between words.
//    Exactly 3 pulls; one underrun pulse at the end.
// 3. FORCE_FRAMING=1, word 0x7FFF_BFFF -> transmitted word 0xBFFE_7FFE, i.e. the lane shows 10,11x6,10,01,11x6,10.
//    Feed it to the RX deframer and check it recovers 0xBFFE_7FFE.
// 4. Drop enable at cnt==8 of word 1 with word 2 in the hold register -> word 1 completes, then 00s, no underrun.
//    Re-enable -> word 2 is sent, with no new pull before its LOAD.
// 5. Assert i_rst_b=0 at cnt==5 -> o_ddr_data=00 and o_fifo_pull=0 immediately (asynchronous).
//    After release the next FIFO word starts fresh with 10.
// 6. FIFO empties mid-stream for 40 cycles -> one underrun pulse, then 00s.
//    On refill: pull, then the first symbol 10 appears 2 edges later.

Source files
------------

// File: rtl/lvds_tx.sv
// LVDS DDR transmit serialiser: pulls 32-bit I/Q words from the TX FIFO
// and shifts them MSB pair first onto a 2-bit DDR lane, 16 symbols/word.
//
// Ports:
//   i_ddr_clk        symbol clock, one 2-bit symbol per rising edge
//   i_rst_b          asynchronous reset, active low
//   i_tx_enable      stream words; when low, finish current word then idle
//   i_fifo_empty     TX FIFO empty flag
//   i_fifo_data      FIFO read data, valid on the edge after a pull
//   o_fifo_read_clk  FIFO read clock (same as i_ddr_clk)
//   o_fifo_pull      registered FIFO read strobe, one cycle per word
//   o_ddr_data       registered symbol to the DDR output cells
//   o_underrun       one-cycle pulse: word ended while enabled, none ready
//   o_debug_state    00 idle, 01 transmitting
module lvds_tx #(
    parameter logic [1:0] IDLE_SYMBOL   = 2'b00,
    parameter bit         FORCE_FRAMING = 1'b1
) (
    input  logic        i_ddr_clk,
    input  logic        i_rst_b,
    input  logic        i_tx_enable,
    input  logic        i_fifo_empty,
    input  logic [31:0] i_fifo_data,
    output logic        o_fifo_read_clk,
    output logic        o_fifo_pull,
    output logic [1:0]  o_ddr_data,
    output logic        o_underrun,
    output logic [1:0]  o_debug_state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        TX   = 2'b01
    } state_t;

    state_t      state_q;
    logic [31:0] hold_q;
    logic        hold_valid_q;
    logic [31:0] shreg_q;
    logic [3:0]  cnt_q;
    logic [1:0]  ddr_q;
    logic        pull_q;
    logic        underrun_q;
    logic [31:0] framed_d;

    // Sync patterns the RX deframer locks on: '10' ahead of I, '01' ahead of Q,
    // and a trailing 0 after each 13-bit sample.
    always_comb begin
        framed_d = i_fifo_data;
        if (FORCE_FRAMING) begin
            framed_d = {2'b10, i_fifo_data[29:17], 1'b0,
                        2'b01, i_fifo_data[13:1], 1'b0};
        end
    end

    always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            shreg_q      <= '0;
            cnt_q        <= '0;
            ddr_q        <= IDLE_SYMBOL;
            pull_q       <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            // Only pull into an empty hold register, so a capture can never
            // land on the same edge as a load.
            pull_q <= i_tx_enable & ~i_fifo_empty & ~hold_valid_q & ~pull_q;
            underrun_q <= 1'b0;

            if (pull_q) begin
                hold_q       <= framed_d;
                hold_valid_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (i_tx_enable && hold_valid_q) begin
                        ddr_q        <= hold_q[31:30];
                        shreg_q      <= {hold_q[29:0], 2'b00};
                        cnt_q        <= 4'd15;
                        hold_valid_q <= 1'b0;
                        state_q      <= TX;
                    end else begin
                        ddr_q <= IDLE_SYMBOL;
                    end
                end
                TX: begin
                    if (cnt_q != 4'd0) begin
                        ddr_q   <= shreg_q[31:30];
                        shreg_q <= {shreg_q[29:0], 2'b00};
                        cnt_q   <= cnt_q - 4'd1;
                    end else if (i_tx_enable && hold_valid_q) begin
                        // Back-to-back: next word follows with no gap.
                        ddr_q        <= hold_q[31:30];
                        shreg_q      <= {hold_q[29:0], 2'b00};
                        cnt_q        <= 4'd15;
                        hold_valid_q <= 1'b0;
                    end else begin
                        ddr_q      <= IDLE_SYMBOL;
                        underrun_q <= i_tx_enable;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    ddr_q   <= IDLE_SYMBOL;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_fifo_read_clk = i_ddr_clk;
    assign o_fifo_pull     = pull_q;
    assign o_ddr_data      = ddr_q;
    assign o_underrun      = underrun_q;
    assign o_debug_state   = state_q;

endmodule

// File: tb/tb_lvds_tx.sv
// Scoreboard bench for lvds_tx: expected symbols/words are queued with
// the stimulus and a negedge monitor pops and compares lane symbols.
module tb_lvds_tx;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        en;
    logic        fifo_empty;
    logic [31:0] fifo_data;
    logic        fifo_rclk;
    logic        fifo_pull;
    logic [1:0]  ddr;
    logic        underrun;
    logic [1:0]  dbg;

    lvds_tx dut (
        .i_ddr_clk       (clk),
        .i_rst_b         (rst_b),
        .i_tx_enable     (en),
        .i_fifo_empty    (fifo_empty),
        .i_fifo_data     (fifo_data),
        .o_fifo_read_clk (fifo_rclk),
        .o_fifo_pull     (fifo_pull),
        .o_ddr_data      (ddr),
        .o_underrun      (underrun),
        .o_debug_state   (dbg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_pull = 0;
    int n_und  = 0;
    int rx_n   = 0;
    logic [31:0] rx_word = '0;

    logic [31:0] fifo_q[$];
    logic [1:0]  sym_q[$];
    logic [31:0] word_q[$];
    bit          pop_pend = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // FIFO model: word at the head is presented until the edge after a pull.
    always @(negedge clk) begin
        if (pop_pend && fifo_q.size() > 0) void'(fifo_q.pop_front());
        pop_pend   = fifo_pull;
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : 32'hDEAD_BEEF;
    end

    // Monitor: every TX cycle carries exactly one expected symbol; each
    // 16 symbols are reassembled into a word like the RX deframer would.
    always @(negedge clk) begin
        if (rst_b === 1'b1) begin
            if (fifo_pull) n_pull++;
            if (underrun) n_und++;
            if (dbg == 2'b01) begin
                if (sym_q.size() == 0) begin
                    chk("unexpected_symbol", {30'd0, ddr}, 32'hFFFF_FFFF);
                end else begin
                    chk("lane_symbol", {30'd0, ddr}, {30'd0, sym_q.pop_front()});
                end
                rx_word = {rx_word[29:0], ddr};
                rx_n++;
                if (rx_n == 16) begin
                    rx_n = 0;
                    if (word_q.size() == 0)
                        chk("unexpected_word", rx_word, 32'hFFFF_FFFF);
                    else
                        chk("rx_word", rx_word, word_q.pop_front());
                end
            end
        end
    end

    task automatic exp_word(input logic [31:0] framed);
        word_q.push_back(framed);
        for (int k = 0; k < 16; k++)
            sym_q.push_back(framed[31-2*k -: 2]);
    endtask

    task automatic send(input logic [31:0] raw, input logic [31:0] framed);
        fifo_q.push_back(raw);
        exp_word(framed);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_st(input logic [1:0] s, input string name);
        int b = 0;
        while (dbg !== s && b < 200) begin
            step(1);
            b++;
        end
        if (dbg !== s) chk(name, {30'd0, dbg}, {30'd0, s});
    endtask

    int p0, u0, n, k;

    initial begin
        rst_b = 1'b1;
        en    = 1'b0;
        fifo_empty = 1'b1;
        fifo_data  = '0;
        #1 rst_b = 1'b0;
        #3;
        chk("rst_ddr", {30'd0, ddr}, 32'd0);
        chk("rst_pull", {31'd0, fifo_pull}, 32'd0);
        chk("rst_und", {31'd0, underrun}, 32'd0);
        chk("rst_state", {30'd0, dbg}, 32'd0);
        chk("rclk", {31'd0, fifo_rclk}, {31'd0, clk});
        step(2);
        rst_b = 1'b1;
        en    = 1'b1;
        step(3);

        // 1: single I=0,Q=0 word, then underrun
        p0 = n_pull; u0 = n_und;
        send(32'h8000_4000, 32'h8000_4000);
        wait_st(2'b01, "t1_start");
        wait_st(2'b00, "t1_end");
        chk("t1_und_pulse", {31'd0, underrun}, 32'd1);
        chk("t1_idle_sym", {30'd0, ddr}, 32'd0);
        step(3);
        chk("t1_pulls", n_pull - p0, 32'd1);
        chk("t1_unds", n_und - u0, 32'd1);

        // 2: three words back to back
        p0 = n_pull; u0 = n_und;
        send(32'hAAAA_5554, 32'hAAAA_5554);
        send(32'h9234_6ABC, 32'h9234_6ABC);
        send(32'h8002_4002, 32'h8002_4002);
        wait_st(2'b01, "t2_start");
        n = 0;
        while (dbg == 2'b01 && n < 200) begin
            n++;
            step(1);
        end
        chk("t2_contig", n, 32'd48);
        chk("t2_und_pulse", {31'd0, underrun}, 32'd1);
        step(3);
        chk("t2_pulls", n_pull - p0, 32'd3);
        chk("t2_unds", n_und - u0, 32'd1);

        // 3: forced framing on an all-ones word
        send(32'h7FFF_BFFF, 32'hBFFE_7FFE);
        wait_st(2'b01, "t3_start");
        wait_st(2'b00, "t3_end");
        step(3);

        // 4: enable drops at cnt==8 with word 2 held
        p0 = n_pull; u0 = n_und;
        send(32'hAAAA_5554, 32'hAAAA_5554);
        send(32'h9234_6ABC, 32'h9234_6ABC);
        wait_st(2'b01, "t4_start");
        step(7);
        en = 1'b0;
        wait_st(2'b00, "t4_end1");
        chk("t4_no_und", {31'd0, underrun}, 32'd0);
        step(10);
        chk("t4_idle_state", {30'd0, dbg}, 32'd0);
        chk("t4_idle_sym", {30'd0, ddr}, 32'd0);
        chk("t4_pulls_held", n_pull - p0, 32'd2);
        chk("t4_unds_held", n_und - u0, 32'd0);
        en = 1'b1;
        wait_st(2'b01, "t4_restart");
        chk("t4_no_new_pull", n_pull - p0, 32'd2);
        chk("t4_first_sym", {30'd0, ddr}, 32'd2);
        wait_st(2'b00, "t4_end2");
        chk("t4_final_und", {31'd0, underrun}, 32'd1);
        step(3);

        // 5: async reset at cnt==5 discards word 1 and the held word 2
        send(32'h8002_4002, 32'h8002_4002);
        send(32'hAAAA_5554, 32'hAAAA_5554);
        fifo_q.push_back(32'h9234_6ABC);
        wait_st(2'b01, "t5_start");
        step(10);
        #1 rst_b = 1'b0;
        #1;
        chk("t5_rst_ddr", {30'd0, ddr}, 32'd0);
        chk("t5_rst_pull", {31'd0, fifo_pull}, 32'd0);
        chk("t5_rst_state", {30'd0, dbg}, 32'd0);
        sym_q.delete();
        word_q.delete();
        rx_n = 0;
        exp_word(32'h9234_6ABC);
        step(2);
        rst_b = 1'b1;
        wait_st(2'b01, "t5_restart");
        chk("t5_fresh_sym", {30'd0, ddr}, 32'd2);
        wait_st(2'b00, "t5_end");
        step(3);

        // 6: FIFO dry for 40 cycles, then refill latency
        p0 = n_pull; u0 = n_und;
        send(32'h8000_4000, 32'h8000_4000);
        wait_st(2'b01, "t6_start");
        wait_st(2'b00, "t6_end");
        step(40);
        chk("t6_one_und", n_und - u0, 32'd1);
        chk("t6_idle_sym", {30'd0, ddr}, 32'd0);
        send(32'hAAAA_5554, 32'hAAAA_5554);
        k = 0;
        while (fifo_pull !== 1'b1 && k < 50) begin
            step(1);
            k++;
        end
        chk("t6_pull_seen", {31'd0, fifo_pull}, 32'd1);
        k = 0;
        while (dbg !== 2'b01 && k < 50) begin
            step(1);
            k++;
        end
        chk("t6_refill_lat", k, 32'd2);
        chk("t6_first_sym", {30'd0, ddr}, 32'd2);
        wait_st(2'b00, "t6_end2");
        step(4);
        chk("t6_pulls", n_pull - p0, 32'd2);

        chk("sym_q_drained", sym_q.size(), 32'd0);
        chk("word_q_drained", word_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
